// File: rtl/sifive_insight_tl_a_echo_tracker.sv
// Per-source echo tracker for the TileLink A channel: captures echo on accepted
// first beats, replays it on D, and stalls A while a source ID is still in flight.
module sifive_insight_tl_a_echo_tracker #(
  parameter int SOURCE_BITS = 4,
  parameter int ECHO_BITS   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid_in,
  output logic                   a_ready_out,
  output logic                   a_valid_out,
  input  logic                   a_ready_in,
  input  logic                   a_first,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ECHO_BITS-1:0]   a_echo,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic                   d_last,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic [ECHO_BITS-1:0]   d_echo,
  output logic                   d_echo_valid,
  output logic [SOURCE_BITS:0]   outstanding,
  output logic                   err_orphan,
  input  logic                   err_clear
);

  localparam int ENTRIES = 1 << SOURCE_BITS;
  localparam logic [SOURCE_BITS:0] CNT_ONE = (SOURCE_BITS + 1)'(1);

  logic [ENTRIES-1:0]   busy;
  logic [ENTRIES-1:0]   busy_nxt;
  logic [ECHO_BITS-1:0] echo_mem [ENTRIES];
  logic [SOURCE_BITS:0] outstanding_nxt;
  logic                 blk;
  logic                 a_fire;
  logic                 capture;
  logic                 d_fire;
  logic                 retire;
  logic                 orphan;

  // blk uses the pre-edge busy value, so a retire in this cycle cannot unblock
  // a same-source capture until the following cycle.
  assign blk         = a_first & busy[a_source];
  assign a_valid_out = a_valid_in & ~blk & reset_n;
  assign a_ready_out = a_ready_in & ~blk;
  assign a_fire      = a_valid_in & a_ready_in & ~blk;
  assign capture     = a_fire & a_first;

  assign d_fire  = d_valid & d_ready;
  assign retire  = d_fire & d_last & busy[d_source];
  assign orphan  = d_fire & ~busy[d_source];

  assign d_echo       = echo_mem[d_source];
  assign d_echo_valid = busy[d_source];

  always_comb begin
    busy_nxt = busy;
    if (retire)  busy_nxt[d_source] = 1'b0;
    if (capture) busy_nxt[a_source] = 1'b1;
  end

  always_comb begin
    outstanding_nxt = outstanding;
    case ({capture, retire})
      2'b10:   outstanding_nxt = outstanding + CNT_ONE;
      2'b01:   outstanding_nxt = outstanding - CNT_ONE;
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= outstanding_nxt;
      if (orphan)         err_orphan <= 1'b1;
      else if (err_clear) err_orphan <= 1'b0;
    end
  end

  // Echo storage carries no reset; contents are only meaningful while busy.
  always_ff @(posedge clock) begin
    if (capture) echo_mem[a_source] <= a_echo;
  end

`ifndef SYNTHESIS
  a_outstanding_matches_busy: assert property (
    @(posedge clock) disable iff (!reset_n) outstanding == ($countones(busy))
  );
  a_no_valid_when_blocked: assert property (
    @(posedge clock) disable iff (!reset_n) blk |-> !a_valid_out
  );
`endif

endmodule

// File: tb/tb_sifive_insight_tl_a_echo_tracker.sv
// Directed bench for the A-channel echo tracker: a table-level model of busy,
// echo and error state is checked against the DUT every cycle, plus pinned literals.
module tb_sifive_insight_tl_a_echo_tracker;
  localparam int SB = 4;
  localparam int EB = 8;
  localparam int N  = 1 << SB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_valid_in = 1'b0, a_ready_in = 1'b0, a_first = 1'b0;
  logic [SB-1:0] a_source = '0, d_source = '0;
  logic [EB-1:0] a_echo = '0;
  logic          d_valid = 1'b0, d_ready = 1'b0, d_last = 1'b0, err_clear = 1'b0;
  logic          a_ready_out, a_valid_out, d_echo_valid, err_orphan;
  logic [EB-1:0] d_echo;
  logic [SB:0]   outstanding;

  int n_cmp = 0;
  int n_err = 0;

  bit        m_busy [N];
  bit [7:0]  m_echo [N];
  bit        m_err;

  sifive_insight_tl_a_echo_tracker #(.SOURCE_BITS(SB), .ECHO_BITS(EB)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid_in(a_valid_in), .a_ready_out(a_ready_out),
    .a_valid_out(a_valid_out), .a_ready_in(a_ready_in),
    .a_first(a_first), .a_source(a_source), .a_echo(a_echo),
    .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last),
    .d_source(d_source), .d_echo(d_echo), .d_echo_valid(d_echo_valid),
    .outstanding(outstanding), .err_orphan(err_orphan), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a source is in flight from an accepted first beat until its last D beat.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      bit was_a, was_d, stalled, take, dfire;
      was_a   = m_busy[a_source];
      was_d   = m_busy[d_source];
      stalled = a_first && was_a;
      take    = a_valid_in && a_ready_in && a_first && !stalled;
      dfire   = d_valid && d_ready;
      if (dfire && d_last && was_d) m_busy[d_source] = 1'b0;
      if (take) begin
        m_busy[a_source] = 1'b1;
        m_echo[a_source] = a_echo;
      end
      if (dfire && !was_d) m_err = 1'b1;
      else if (err_clear)  m_err = 1'b0;
    end
  end

  always @(negedge clock) begin
    bit stalled;
    stalled = a_first && m_busy[a_source];
    chk("a_valid_out", int'(a_valid_out), int'(reset_n && a_valid_in && !stalled));
    chk("a_ready_out", int'(a_ready_out), int'(a_ready_in && !stalled));
    chk("d_echo_valid", int'(d_echo_valid), int'(m_busy[d_source]));
    chk("outstanding", int'(outstanding), m_count());
    chk("err_orphan", int'(err_orphan), int'(m_err));
    if (m_busy[d_source]) chk("d_echo", int'(d_echo), int'(m_echo[d_source]));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_valid_in = 0; a_ready_in = 0; a_first = 0;
    d_valid = 0; d_ready = 0; d_last = 0; err_clear = 0;
  endtask

  task automatic drive_a(input int src, input int echo);
    a_valid_in = 1; a_ready_in = 1; a_first = 1;
    a_source = SB'(src); a_echo = EB'(echo);
  endtask

  task automatic drive_d(input int src, input bit last);
    d_valid = 1; d_ready = 1; d_last = last; d_source = SB'(src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // In reset: a_valid_out held low, a_ready_out follows a_ready_in.
    a_valid_in = 1; a_ready_in = 1; a_first = 1; a_source = 4'd3;
    #2;
    chk("rst_a_valid_out", int'(a_valid_out), 0);
    chk("rst_a_ready_out_hi", int'(a_ready_out), 1);
    a_ready_in = 0;
    #1;
    chk("rst_a_ready_out_lo", int'(a_ready_out), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    @(posedge clock); #1;
    reset_n = 1;
    idle();

    // Basic capture and replay on src 3.
    drive_a(3, 8'hA5);
    #1 chk("t1_a_ready", int'(a_ready_out), 1);
    cyc(); idle(); d_source = 4'd3;
    #1 chk("t1_busy3", int'(d_echo_valid), 1);
    chk("t1_outst1", int'(outstanding), 1);
    drive_d(3, 1);
    #1 chk("t1_replay", int'(d_echo), 8'hA5);
    cyc(); idle();
    #1 chk("t1_outst0", int'(outstanding), 0);

    // Re-issue of src 5 stalls until its last D beat has retired.
    drive_a(5, 8'h11);
    cyc();
    drive_a(5, 8'h22);
    #1 chk("t2_blk_valid", int'(a_valid_out), 0);
    chk("t2_blk_ready", int'(a_ready_out), 0);
    cyc();
    drive_d(5, 1);
    #1 chk("t2_blk_same_cycle", int'(a_ready_out), 0);
    cyc();
    d_valid = 0; d_ready = 0; d_last = 0;
    #1 chk("t2_unblocked", int'(a_ready_out), 1);
    cyc(); idle(); d_source = 4'd5;
    #1 chk("t2_new_echo", int'(d_echo), 8'h22);
    drive_d(5, 1);
    cyc(); idle();

    // Four-beat D burst, last only on beat 4.
    drive_a(2, 8'h3C);
    cyc(); idle();
    for (int b = 1; b <= 4; b++) begin
      drive_d(2, b == 4);
      #1 chk("t3_burst_echo", int'(d_echo), 8'h3C);
      chk("t3_burst_busy", int'(d_echo_valid), 1);
      chk("t3_burst_outst", int'(outstanding), 1);
      cyc();
    end
    idle();
    #1 chk("t3_retired", int'(d_echo_valid), 0);
    chk("t3_outst0", int'(outstanding), 0);

    // Fill the table, then recycle entries.
    for (int i = 0; i < N; i++) begin
      drive_a(i, 8'h40 + i);
      cyc();
    end
    idle();
    #1 chk("t4_full", int'(outstanding), 16);
    drive_d(0, 1); drive_a(0, 8'h99);
    #1 chk("t4_full_blk", int'(a_ready_out), 0);
    cyc();
    d_valid = 0; d_ready = 0; d_last = 0;
    #1 chk("t4_after_retire", int'(outstanding), 15);
    cyc(); idle(); d_source = 4'd0;
    #1 chk("t4_refill", int'(outstanding), 16);
    chk("t4_new_echo0", int'(d_echo), 8'h99);
    drive_d(1, 1);
    cyc(); idle();
    drive_d(2, 1); drive_a(1, 8'h77);
    cyc(); idle(); d_source = 4'd1;
    #1 chk("t4_net_zero", int'(outstanding), 15);
    chk("t4_echo1", int'(d_echo), 8'h77);

    // Orphan handling on the now-free src 2.
    drive_d(2, 0);
    cyc(); idle();
    #1 chk("t5_orphan_set", int'(err_orphan), 1);
    cyc();
    #1 chk("t5_orphan_sticky", int'(err_orphan), 1);
    err_clear = 1;
    cyc(); idle();
    #1 chk("t5_cleared", int'(err_orphan), 0);
    drive_d(2, 0); err_clear = 1;
    cyc(); idle();
    #1 chk("t5_set_wins", int'(err_orphan), 1);
    err_clear = 1;
    cyc(); idle();
    drive_a(2, 8'hE1); drive_d(2, 1);
    cyc(); idle(); d_source = 4'd2;
    #1 chk("t5_same_src_busy", int'(d_echo_valid), 1);
    chk("t5_same_src_err", int'(err_orphan), 1);
    chk("t5_same_src_echo", int'(d_echo), 8'hE1);

    // Asynchronous reset mid-operation, between clock edges.
    #1 reset_n = 0;
    #1 chk("t6_outst", int'(outstanding), 0);
    chk("t6_err", int'(err_orphan), 0);
    for (int i = 0; i < N; i++) begin
      d_source = SB'(i);
      #0 chk("t6_busy_clr", int'(d_echo_valid), 0);
    end
    @(posedge clock); #1;
    reset_n = 1;
    drive_a(9, 8'h5A);
    #1 chk("t6_accept", int'(a_ready_out), 1);
    cyc(); idle(); d_source = 4'd9;
    #1 chk("t6_outst1", int'(outstanding), 1);
    chk("t6_echo", int'(d_echo), 8'h5A);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
